// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch unit and imem.
//   req    : fetch request, held until gnt
//   addr   : fetch address, stable while req=1
//   gnt    : request accepted this cycle
//   rvalid : rdata valid this cycle (no earlier than the cycle after gnt)
//   rdata  : fetched instruction word
// master = fetch unit side, slave = memory side.
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter / instruction-fetch front end.
// Picks the next PC from PCSrc and the branch/JALR targets, fetches one
// instruction at a time over the imem req/gnt/rvalid handshake, and holds it
// for the execute path until consumed (stall=0). A taken target that is not
// word-aligned raises a sticky trap that only reset clears.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pc_src, jalr               next-PC select from BranchLogic
//   branch_target, jalr_target candidate targets (jalr bit0 cleared here)
//   stall                      1 = current instruction not consumed
//   imem                       fetch handshake (master side)
//   inst_valid, inst, pc       current instruction and its address
//   misalign_trap, trap_addr   sticky misalignment flag and offending target
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_src,
  input  logic                   jalr,
  input  logic [31:0]            branch_target,
  input  logic [31:0]            jalr_target,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            pc,
  output logic                   misalign_trap,
  output logic [31:0]            trap_addr
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, TRAP} state_t;

  state_t      state, state_d;
  logic [31:0] tgt, nxt;
  logic        load_inst, adv_pc, drop_inst, set_trap;

  // Only one fetch is ever outstanding, so the fetch address is simply pc.
  assign imem.req  = (state == REQ);
  assign imem.addr = pc;

  // JALR clears bit0 of its target; only bit1 can still misalign it.
  assign tgt = jalr ? (jalr_target & 32'hFFFF_FFFE) : branch_target;
  assign nxt = pc_src ? tgt : (pc + 32'd4);

  always_comb begin
    state_d   = state;
    load_inst = 1'b0;
    adv_pc    = 1'b0;
    drop_inst = 1'b0;
    set_trap  = 1'b0;
    case (state)
      IDLE:  state_d = REQ;
      REQ:   if (imem.gnt) state_d = WAIT;
      WAIT:  if (imem.rvalid) begin
               load_inst = 1'b1;
               state_d   = VALID;
             end
      VALID: if (!stall) begin
               drop_inst = 1'b1;
               if (nxt[1:0] == 2'b00) begin
                 adv_pc  = 1'b1;
                 state_d = REQ;
               end else begin
                 // pc is left pointing at the instruction that branched.
                 set_trap = 1'b1;
                 state_d  = TRAP;
               end
             end
      TRAP:  state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      inst          <= NOP_INST;
      inst_valid    <= 1'b0;
      misalign_trap <= 1'b0;
      trap_addr     <= 32'h0;
    end else begin
      state <= state_d;
      if (load_inst) begin
        inst       <= imem.rdata;
        inst_valid <= 1'b1;
      end
      if (drop_inst) begin
        inst       <= NOP_INST;
        inst_valid <= 1'b0;
      end
      if (adv_pc) pc <= nxt;
      if (set_trap) begin
        misalign_trap <= 1'b1;
        trap_addr     <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a random imem responder, a
// reference model of the PC sequence that queues expected {pc, inst} pairs,
// and a monitor that pops and compares every time a new instruction appears.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0, jalr = 1'b0, stall = 1'b1;
  logic [31:0] branch_target = '0, jalr_target = '0;
  logic        inst_valid, misalign_trap;
  logic [31:0] inst, pc, trap_addr;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .jalr(jalr),
    .branch_target(branch_target), .jalr_target(jalr_target), .stall(stall),
    .imem(imem), .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .misalign_trap(misalign_trap), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errs = 0;
  exp_t exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int   gnt_lat = 0;   // <0 selects random latency
  int   rv_lat = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // imem responder: drives shortly after the rising edge.
  initial begin
    bit          pend, seen;
    int          wg, wr;
    logic [31:0] paddr;
    pend = 0; seen = 0; wg = 0; wr = 0; paddr = '0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0;
    forever begin
      @(posedge clk); #1;
      imem.gnt = 0; imem.rvalid = 0;
      if (!rst_n) begin
        pend = 0; seen = 0;
      end else if (pend) begin
        if (wr == 0) begin
          imem.rvalid = 1; imem.rdata = mem_fn(paddr); pend = 0;
        end else wr--;
      end else if (imem.req) begin
        if (!seen) begin
          seen = 1;
          wg = (gnt_lat < 0) ? int'($urandom_range(0, 3)) : gnt_lat;
        end
        if (wg == 0) begin
          imem.gnt = 1; paddr = imem.addr; pend = 1; seen = 0;
          wr = (rv_lat < 0) ? int'($urandom_range(0, 2)) : rv_lat;
        end else wg--;
      end
    end
  end

  // Monitor: compares each newly presented instruction with the scoreboard.
  initial begin
    logic        prev_v, prev_req, prev_gnt;
    logic [31:0] prev_addr;
    exp_t        e;
    prev_v = 0; prev_req = 0; prev_gnt = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0; prev_req = 0; prev_gnt = 0;
      end else begin
        if (inst_valid && !prev_v) begin
          if (exp_q.size() == 0) chk("unexpected_inst", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("inst_pc", pc, e.pc);
            chk("inst_word", inst, e.inst);
          end
        end
        if (!inst_valid) chk("nop_when_invalid", inst, NOP_INST);
        if (misalign_trap) chk("no_req_in_trap", imem.req, 0);
        if (prev_req && !prev_gnt) begin
          chk("req_held", imem.req, 1);
          chk("addr_held", imem.addr, prev_addr);
        end
        prev_v = inst_valid; prev_req = imem.req;
        prev_gnt = imem.gnt; prev_addr = imem.addr;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_req", imem.req, 0);
    chk("rst_trap", misalign_trap, 0);
    chk("rst_trap_addr", trap_addr, 0);
    exp_q.delete();
    model_pc = RESET_PC;
    exp_q.push_back('{RESET_PC, mem_fn(RESET_PC)});
    @(negedge clk);
    rst_n = 1;
  endtask

  // Wait for a held instruction, optionally stall, then consume with the
  // given next-PC selection and check the model's prediction.
  task automatic step(input int n_stall, input logic s, input logic j,
                      input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] nxt;
    int t;
    t = 0;
    while (!inst_valid && t < 64) begin @(negedge clk); t++; end
    if (!inst_valid) begin chk("inst_valid_timeout", 0, 1); return; end
    for (int i = 0; i < n_stall; i++) begin
      pc_src = 1'($urandom); jalr = 1'($urandom); branch_target = $urandom;
      @(negedge clk);
      chk("stall_pc_hold", pc, model_pc);
      chk("stall_valid_hold", inst_valid, 1);
      chk("stall_no_req", imem.req, 0);
    end
    stall = 0; pc_src = s; jalr = j; branch_target = bt; jalr_target = jt;
    nxt = s ? (j ? (jt & 32'hFFFF_FFFE) : bt) : model_pc + 32'd4;
    @(negedge clk);
    stall = 1;
    if (nxt[1:0] == 2'b00) begin
      exp_q.push_back('{nxt, mem_fn(nxt)});
      model_pc = nxt;
      chk("req_after_consume", imem.req, 1);
      chk("fetch_addr", imem.addr, nxt);
    end else begin
      chk("trap_set", misalign_trap, 1);
      chk("trap_addr", trap_addr, nxt);
      chk("trap_inst_valid", inst_valid, 0);
      chk("trap_pc_kept", pc, model_pc);
      repeat (5) @(negedge clk);
      chk("trap_sticky", misalign_trap, 1);
      chk("trap_no_valid", inst_valid, 0);
    end
  endtask

  initial begin
    int t;
    logic [31:0] bt, jt;
    // 1: reset, immediate gnt, rvalid one cycle later, first fetch at 0
    do_reset();
    // 2: sequential fetch with gnt withheld 3 cycles
    step(0, 1, 0, 32'h10, 0);
    gnt_lat = 3;
    step(0, 0, 0, 0, 0);
    gnt_lat = 0;
    // 3: stall two cycles at 0x20, then taken branch to 0x40
    step(0, 1, 0, 32'h20, 0);
    step(2, 1, 0, 32'h40, 0);
    // 4: JALR target with bit0 set
    step(1, 1, 1, 32'hDEAD_BEE0, 32'h0000_0105);
    // PC wrap past the top of the address space
    step(0, 1, 0, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0);
    // randomized traffic
    gnt_lat = -1; rv_lat = -1;
    for (int i = 0; i < 120; i++) begin
      bt = $urandom & 32'h0003_FFFC;
      jt = $urandom & 32'h0003_FFFD;
      if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFFC;
      step($urandom_range(0, 3), 1'($urandom), 1'($urandom), bt, jt);
    end
    // 5: misaligned branch target traps, reset recovers
    step(0, 1, 0, 32'h0000_0042, 0);
    do_reset();
    gnt_lat = 0; rv_lat = 0;
    // JALR misaligned through bit1
    step(0, 1, 1, 0, 32'h0000_0107);
    do_reset();
    // 6: async reset in WAIT coinciding with rvalid
    step(0, 1, 0, 32'h0000_0800, 0);
    rv_lat = 1;
    t = 0;
    imem_wait: while (t < 64) begin
      @(posedge clk); #2;
      if (imem.rvalid) break;
      t++;
    end
    if (!imem.rvalid) chk("rvalid_timeout", 0, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_inst_valid", inst_valid, 0);
    chk("mid_rst_inst", inst, NOP_INST);
    chk("mid_rst_req", imem.req, 0);
    chk("mid_rst_pc", pc, RESET_PC);
    @(negedge clk);
    chk("mid_rst_discard", inst_valid, 0);
    exp_q.delete();
    model_pc = RESET_PC;
    exp_q.push_back('{RESET_PC, mem_fn(RESET_PC)});
    rv_lat = 0;
    rst_n = 1;
    step(0, 0, 0, 0, 0);
    // drain the last fetch
    t = 0;
    while (!inst_valid && t < 64) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
